// File: rtl/adder.sv
// Registered WIDTH-bit adder with carry, signed-overflow and zero flags; one-cycle latency.
// Define ADDER_SATURATE_EN to clamp the sum to all ones on unsigned carry-out.
module adder #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             out_valid
);

    logic [WIDTH:0]   raw;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             carry_d, carry_q;
    logic             ovf_d, ovf_q;
    logic             zero_d, zero_q;
    logic             valid_q;

    always_comb begin
        raw     = {1'b0, ain} + {1'b0, bin};
        sum_d   = raw[WIDTH-1:0];
        carry_d = raw[WIDTH];
        // Overflow always reflects the unclamped sum, even when saturating.
        ovf_d   = (ain[WIDTH-1] == bin[WIDTH-1]) && (raw[WIDTH-1] != ain[WIDTH-1]);
`ifdef ADDER_SATURATE_EN
        if (raw[WIDTH]) begin
            sum_d = '1;
        end
`else
`endif
        zero_d  = (sum_d == '0);
    end

    always_ff @(posedge clock) begin
        // NOTE: the missing else on in_valid is a clock-enable hold on flops, not a latch.
        if (reset) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
                ovf_q   <= ovf_d;
                zero_q  <= zero_d;
            end
        end
    end

    assign out       = sum_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_adder.sv
// Directed bench for adder: a scoreboard queue holds each accepted pair's expected flags
// until the registered result appears; idle and reset cycles are checked against held state.
module tb_adder;

    localparam int WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             c;
        logic             ov;
        logic             z;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] ain = '0;
    logic [WIDTH-1:0] bin = '0;
    logic [WIDTH-1:0] out;
    logic             carry, overflow, zero, out_valid;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    exp_t held = '0;

    adder #(.WIDTH(WIDTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .ain      (ain),
        .bin      (bin),
        .out      (out),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .out_valid(out_valid)
    );

    always #5 clock = ~clock;

    // Reference built from integer arithmetic, independent of bit-slicing.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        int   u;
        int   s;
        u = int'(a) + int'(b);
        s = (a[WIDTH-1] ? int'(a) - (1 << WIDTH) : int'(a))
          + (b[WIDTH-1] ? int'(b) - (1 << WIDTH) : int'(b));
        e.c  = (u >= (1 << WIDTH));
        e.ov = (s > (1 << (WIDTH-1)) - 1) || (s < -(1 << (WIDTH-1)));
`ifdef ADDER_SATURATE_EN
        e.sum = e.c ? {WIDTH{1'b1}} : WIDTH'(u % (1 << WIDTH));
`else
        e.sum = WIDTH'(u % (1 << WIDTH));
`endif
        e.z = (e.sum == '0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_fields(input string tag, input exp_t e);
        chk({tag, ".out"},      32'(out),      32'(e.sum));
        chk({tag, ".carry"},    32'(carry),    32'(e.c));
        chk({tag, ".overflow"}, 32'(overflow), 32'(e.ov));
        chk({tag, ".zero"},     32'(zero),     32'(e.z));
    endtask

    // Drive one cycle at the falling edge, then check 1 time unit after the rising edge.
    task automatic step(input string tag, input logic rst, input logic v,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        @(negedge clock);
        reset    = rst;
        in_valid = v;
        ain      = a;
        bin      = b;
        if (!rst && v) sb_q.push_back(model(a, b));
        @(posedge clock);
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(!rst && v));
        if (rst) begin
            sb_q.delete();
            held = '0;
            chk_fields(tag, held);
        end else if (v) begin
            if (sb_q.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'(1), 32'(0));
            end else begin
                e    = sb_q.pop_front();
                held = e;
                chk_fields(tag, e);
            end
        end else begin
            chk_fields(tag, held);
        end
    endtask

    initial begin
        step("rst0", 1'b1, 1'b1, 4'b0011, 4'b0001);
        step("rst1", 1'b1, 1'b1, 4'b0011, 4'b0001);
        step("basic", 1'b0, 1'b1, 4'b0001, 4'b0000);
        step("b2b0", 1'b0, 1'b1, 4'b0011, 4'b0001);
        step("b2b1", 1'b0, 1'b1, 4'b0011, 4'b0111);
        step("hold0", 1'b0, 1'b0, 4'b1111, 4'b1111);
        step("wrap", 1'b0, 1'b1, 4'b1001, 4'b0111);
        step("hold1", 1'b0, 1'b0, 4'b0000, 4'b0000);
        step("sovf", 1'b0, 1'b1, 4'b0111, 4'b0001);
        step("hold2", 1'b0, 1'b0, 4'b0101, 4'b0101);
        step("max", 1'b0, 1'b1, 4'b1111, 4'b1111);
        step("negovf", 1'b0, 1'b1, 4'b1000, 4'b1000);
        step("zeros", 1'b0, 1'b1, 4'b0000, 4'b0000);
        step("edge", 1'b0, 1'b1, 4'b1111, 4'b0001);
        step("mid", 1'b0, 1'b1, 4'b0110, 4'b0101);
        step("midrst", 1'b1, 1'b1, 4'b0101, 4'b0110);
        step("post", 1'b0, 1'b0, 4'b0101, 4'b0110);
        for (int i = 0; i < 8; i++) begin
            step("rand", 1'b0, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
